// File: rtl/dmadd_sequencer.sv
// Upstream controller for the delta min/max scanner: loads a batch of sample
// indices into DMADD, runs the scan, and returns the found index on a result port.
module dmadd_sequencer #(
  parameter int SCAN_CYCLES = 17,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [3:0]       s_data,
  input  logic             s_last,
  output logic             dm_rst_n,
  output logic [3:0]       dm_index,
  output logic [3:0]       dm_data,
  output logic [1:0]       dm_insn,
  output logic             dm_load,
  output logic             dm_run,
  input  logic [11:0]      dm_out,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [3:0]       r_index,
  output logic [CNT_W-1:0] r_count,
  output logic             r_empty
);

  localparam int SCW = $clog2(SCAN_CYCLES + 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_SCAN,
    S_CAPT,
    S_RES
  } state_t;

  state_t           r_state;
  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [SCW-1:0]   r_scan_cnt;

  logic             r_cmd_ready;
  logic             r_s_ready;
  logic             r_dm_rst_n;
  logic [3:0]       r_dm_index;
  logic [1:0]       r_dm_insn;
  logic             r_dm_load;
  logic             r_dm_run;
  logic             r_res_valid;
  logic [3:0]       r_res_index;
  logic [CNT_W-1:0] r_res_count;
  logic             r_res_empty;

  // Only the low nibble of the scanner result carries the index.
  logic             w_dm_out_unused;
  assign w_dm_out_unused = ^dm_out[11:4];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_cnt       <= '0;
      r_scan_cnt  <= '0;
      r_cmd_ready <= 1'b0;
      r_s_ready   <= 1'b0;
      r_dm_rst_n  <= 1'b0;
      r_dm_index  <= '0;
      r_dm_insn   <= '0;
      r_dm_load   <= 1'b0;
      r_dm_run    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_index <= '0;
      r_res_count <= '0;
      r_res_empty <= 1'b0;
    end else begin
      r_dm_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dm_rst_n <= 1'b0;
          r_dm_insn  <= '0;
          r_dm_run   <= 1'b0;
          if (r_cmd_ready && cmd_valid) begin
            r_mode      <= cmd_mode;
            r_cnt       <= '0;
            r_dm_rst_n  <= 1'b1;
            r_dm_insn   <= {1'b0, cmd_mode};
            r_cmd_ready <= 1'b0;
            r_s_ready   <= 1'b1;
            r_state     <= S_LOAD;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        // Each accepted sample is presented to DMADD as a one-cycle load pulse.
        S_LOAD: begin
          if (r_s_ready && s_valid) begin
            r_dm_load  <= 1'b1;
            r_dm_index <= s_data;
            r_cnt      <= sat_inc(r_cnt);
            if (s_last) begin
              r_s_ready <= 1'b0;
              r_state   <= S_INIT;
            end
          end
        end
        S_INIT: begin
          r_scan_cnt <= '0;
          r_dm_run   <= 1'b1;
          r_state    <= S_SCAN;
        end
        S_SCAN: begin
          if (r_scan_cnt == SCAN_LAST) begin
            r_dm_run <= 1'b0;
            r_state  <= S_CAPT;
          end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
          end
        end
        S_CAPT: begin
          r_res_index <= dm_out[3:0];
          r_res_count <= r_cnt;
          r_res_empty <= (r_cnt == '0);
          r_res_valid <= 1'b1;
          r_state     <= S_RES;
        end
        // Result is held until taken; leaving here puts DMADD back in reset.
        S_RES: begin
          if (r_ready) begin
            r_res_valid <= 1'b0;
            r_dm_rst_n  <= 1'b0;
            r_dm_insn   <= '0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign s_ready   = r_s_ready;
  assign dm_rst_n  = r_dm_rst_n;
  assign dm_index  = r_dm_index;
  assign dm_data   = r_dm_index;
  assign dm_insn   = r_dm_insn;
  assign dm_load   = r_dm_load;
  assign dm_run    = r_dm_run;
  assign r_valid   = r_res_valid;
  assign r_index   = r_res_index;
  assign r_count   = r_res_count;
  assign r_empty   = r_res_empty;

endmodule

// File: tb/tb_dmadd_sequencer.sv
// Directed bench for dmadd_sequencer with a small DMADD stand-in that marks
// loaded indices and reports the lowest (MIN) or highest (MAX) marked one.
module tb_dmadd_sequencer;
  localparam int SCAN  = 17;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_mode;
  logic             s_valid, s_ready, s_last;
  logic [3:0]       s_data;
  logic             dm_rst_n, dm_load, dm_run;
  logic [3:0]       dm_index, dm_data;
  logic [1:0]       dm_insn;
  logic [11:0]      dm_out;
  logic             r_valid, r_ready, r_empty;
  logic [3:0]       r_index;
  logic [CNT_W-1:0] r_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmadd_sequencer #(.SCAN_CYCLES(SCAN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .dm_rst_n(dm_rst_n), .dm_index(dm_index), .dm_data(dm_data),
    .dm_insn(dm_insn), .dm_load(dm_load), .dm_run(dm_run), .dm_out(dm_out),
    .r_valid(r_valid), .r_ready(r_ready), .r_index(r_index),
    .r_count(r_count), .r_empty(r_empty)
  );

  logic [15:0] mask;
  always @(posedge clk) begin
    if (!dm_rst_n) mask <= '0;
    else if (dm_load) mask[dm_index] <= 1'b1;
  end

  always_comb begin
    dm_out = '0;
    if (dm_insn[0]) begin
      for (int i = 0; i < 16; i++) if (mask[i]) dm_out = 12'(i);
    end else begin
      for (int i = 15; i >= 0; i--) if (mask[i]) dm_out = 12'(i);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic mode);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("cmd_timeout", 1, 0);
    tick();
    cmd_valid = 1'b0;
    chk("cmd_rst_n", dm_rst_n, 1);
    chk("cmd_insn", dm_insn, {1'b0, mode});
    chk("cmd_s_ready", s_ready, 1);
  endtask

  task automatic send_sample(input logic [3:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("smp_timeout", 1, 0);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("smp_load", dm_load, 1);
    chk("smp_index", dm_index, d);
    chk("smp_data", dm_data, d);
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
    chk("gap_load", dm_load, 0);
  endtask

  // Called in the cycle right after the last sample was accepted (L+1).
  task automatic wait_result(input string tag);
    int cyc = 1, runs = 0, loads = 0, rdys = 0;
    while (!r_valid && cyc < 100) begin
      tick();
      cyc++;
      if (dm_run) runs++;
      if (dm_load) loads++;
      if (s_ready || cmd_ready) rdys++;
    end
    chk({tag, "_latency"}, cyc, SCAN + 3);
    chk({tag, "_run_cycles"}, runs, SCAN);
    chk({tag, "_stray_loads"}, loads, 0);
    chk({tag, "_stray_ready"}, rdys, 0);
  endtask

  task automatic take_result(input string tag, input logic [3:0] idx,
                             input logic [CNT_W-1:0] cnt, input int hold);
    int unstable = 0;
    chk({tag, "_index"}, r_index, idx);
    chk({tag, "_count"}, r_count, cnt);
    chk({tag, "_empty"}, r_empty, 0);
    repeat (hold) begin
      tick();
      if (!r_valid || r_index !== idx || r_count !== cnt || !dm_rst_n) unstable++;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, unstable, 0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    chk({tag, "_valid_drop"}, r_valid, 0);
    chk({tag, "_idle_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_idle_rst_n"}, dm_rst_n, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nv;
    rst = 1'b1; cmd_valid = 0; cmd_mode = 0; s_valid = 0; s_data = 0;
    s_last = 0; r_ready = 0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_dm_rst_n", dm_rst_n, 0);
    rst = 1'b0;
    tick(); tick();
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_dm_rst_n", dm_rst_n, 0);
    chk("idle_r_valid", r_valid, 0);
    chk("idle_s_ready", s_ready, 0);
    chk("idle_ctrl", {dm_load, dm_run, dm_insn, dm_index}, 0);
    chk("idle_result", {r_index, r_count, r_empty}, 0);

    // MIN {9,3,12}
    send_cmd(1'b0);
    send_sample(4'd9, 1'b0);
    send_sample(4'd3, 1'b0);
    send_sample(4'd12, 1'b1);
    wait_result("min3");
    take_result("min3", 4'd3, 8'd3, 0);

    // MAX {0,15,7} with gaps, result held 5 cycles
    send_cmd(1'b1);
    gap(2);
    send_sample(4'd0, 1'b0);
    gap(1);
    send_sample(4'd15, 1'b0);
    gap(3);
    send_sample(4'd7, 1'b1);
    wait_result("max3");
    take_result("max3", 4'd15, 8'd3, 5);

    // MAX {5}, then MIN {2} issued immediately
    send_cmd(1'b1);
    send_sample(4'd5, 1'b1);
    wait_result("max1");
    take_result("max1", 4'd5, 8'd1, 0);
    send_cmd(1'b0);
    send_sample(4'd2, 1'b1);
    wait_result("min1");
    take_result("min1", 4'd2, 8'd1, 0);

    // reset during scan cycle 8 abandons the batch
    send_cmd(1'b1);
    send_sample(4'd1, 1'b0);
    send_sample(4'd14, 1'b1);
    repeat (8) tick();
    chk("mid_scan_run", dm_run, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_run", dm_run, 0);
    chk("abort_rst_n", dm_rst_n, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    chk("abort_s_ready", s_ready, 0);
    nv = 0;
    repeat (30) begin tick(); if (r_valid) nv++; end
    chk("abort_no_result", nv, 0);
    send_cmd(1'b0);
    send_sample(4'd4, 1'b1);
    wait_result("after_abort");
    take_result("after_abort", 4'd4, 8'd1, 0);

    // stray s_valid/cmd_valid during scan and result
    send_cmd(1'b0);
    send_sample(4'd10, 1'b0);
    send_sample(4'd7, 1'b1);
    s_valid = 1'b1; s_data = 4'd0; cmd_valid = 1'b1; cmd_mode = 1'b1;
    wait_result("stray");
    nv = 0;
    repeat (3) begin tick(); if (dm_load || s_ready || cmd_ready) nv++; end
    chk("stray_result_phase", nv, 0);
    s_valid = 1'b0; cmd_valid = 1'b0;
    take_result("stray", 4'd7, 8'd2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
